multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter TIMEOUT, default 16, sets the memoryReady wait limit in cycles; 0 disables the timeout.
REQ-002 Parameter ENABLE_IMM_ALU, default 1, decodes I-type ALU opcode 0010011 when 1; when 0 that opcode is illegal.
REQ-003 Parameter ENABLE_JAL, default 1, decodes JAL opcode 1101111 when 1; when 0 that opcode is illegal.
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 opcode  in  7  instruction opcode, bits [6:0] of the instruction register.
REQ-007 memoryReady  in  1  memory handshake; access completes in any cycle it is 1 while a request is driven.
REQ-008 ALUOp  out  2  00 add, 01 subtract/compare, 10 R-type funct decode, 11 I-type funct decode.
REQ-009 ALUSrc, memoryToRegister, rWrite, memoryRead, memoryWrite, branch  out  1 each  datapath controls, same meaning as the single-cycle controller.
REQ-010 jump  out  1  select the JAL target and link write.
REQ-011 PCWrite  out  1  one-cycle PC update strobe.
REQ-012 IRWrite  out  1  instruction register load strobe.
REQ-013 illegal  out  1  sticky trap flag.
REQ-014 state  out  3  current state encoding, for debug.

Function
REQ-015 The FSM SHALL have six states: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5; encodings 6 and 7 SHALL go to TRAP.
REQ-016 All outputs SHALL be Moore: a combinational decode of the state register and the latched class register.
REQ-017 FETCH SHALL drive memoryRead=1 and ALUOp=00.
 - IRWrite=1 and PCWrite=1 only in the cycle memoryReady=1; the next state is DECODE.
 - Otherwise the FSM stays in FETCH.
REQ-018 DECODE SHALL latch the instruction class from opcode.
 - Classes: R 0110011, LD 0000011, SD 0100011, BEQ 1100011, IALU, JAL.
 - Any other opcode, or a disabled class, SHALL go to TRAP; otherwise the next state is EXECUTE.
REQ-019 Changes on opcode after DECODE SHALL have no effect until the next DECODE.
REQ-020 EXECUTE controls and next state by class:
 - R: ALUSrc=0, ALUOp=10; next WRITEBACK.
 - IALU: ALUSrc=1, ALUOp=11; next WRITEBACK.
 - LD/SD: ALUSrc=1, ALUOp=00; next MEMORY.
 - BEQ: ALUSrc=0, ALUOp=01, branch=1, PCWrite=0; next FETCH.
 - JAL: jump=1, ALUOp=00; next WRITEBACK.
REQ-021 MEMORY SHALL drive memoryRead=1 for LD and memoryWrite=1 for SD, holding the request until memoryReady=1.
 - On completion, LD goes to WRITEBACK and SD goes to FETCH.
REQ-022 WRITEBACK SHALL drive rWrite=1 for exactly one cycle, with memoryToRegister=1 for LD and jump=1 for JAL; next FETCH.
REQ-023 Outputs not listed for a state SHALL be 0.
REQ-024 Latency from FETCH entry to the next FETCH, with memoryReady held at 1: BEQ 3 cycles; R/IALU/SD/JAL 4 cycles; LD 5 cycles.
REQ-025 A wait counter SHALL count consecutive cycles in FETCH or MEMORY with memoryReady=0.
 - It SHALL clear on completion or on a state change.
 - Reaching TIMEOUT SHALL go to TRAP; the counter SHALL saturate and never wrap.
REQ-026 TRAP SHALL drive illegal=1 with all other outputs 0, and SHALL hold until reset.
REQ-027 Exactly one of memoryRead or memoryWrite, or neither, SHALL be asserted in any cycle; never both.

Reset
REQ-028 With reset=1 at a rising edge: state becomes FETCH; class register, wait counter and illegal clear.
REQ-029 While reset=1, all outputs except state SHALL be forced to 0.
REQ-030 Reset SHALL take priority over every transition, including mid-MEMORY and in TRAP; no partial write SHALL follow reset.
REQ-031 The first FETCH request SHALL appear in the cycle after reset deasserts.

Verification
REQ-032 Reset released, memoryReady=1, opcode=0110011 -> states 0,1,2,4,0; rWrite=1 only in cycle 4; ALUOp=10 in EXECUTE.
REQ-033 opcode=0000011, memoryReady=0 for 3 cycles in MEMORY -> memoryRead held 4 cycles; then WRITEBACK with rWrite=1 and memoryToRegister=1; total 8 cycles.
REQ-034 opcode=1100011 -> branch=1 and ALUOp=01 in EXECUTE only; return to FETCH after 3 cycles; rWrite never 1.
REQ-035 opcode=1111111, or 0010011 with ENABLE_IMM_ALU=0 -> TRAP after DECODE; illegal=1 held for 10+ cycles; reset clears it.
REQ-036 TIMEOUT=4, memoryReady=0 in FETCH -> TRAP on the 5th cycle; TIMEOUT=0 -> FETCH held indefinitely.
REQ-037 Opcode changed from SD to R during MEMORY -> memoryWrite=1 and no rWrite; reset asserted mid-MEMORY -> memoryWrite=0 in the same cycle, then FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle datapath controller: a six-state Moore FSM that fetches,
// decodes, executes, accesses memory and writes back. It includes a
// memory-wait watchdog and a sticky trap state for illegal opcodes.
module multicycle_controller #(
   parameter int TIMEOUT        = 16,
   parameter bit ENABLE_IMM_ALU = 1'b1,
   parameter bit ENABLE_JAL     = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       memoryReady,
   output logic [1:0] ALUOp,
   output logic       ALUSrc,
   output logic       memoryToRegister,
   output logic       rWrite,
   output logic       memoryRead,
   output logic       memoryWrite,
   output logic       branch,
   output logic       jump,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       illegal,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEMORY    = 3'd3,
      WRITEBACK = 3'd4,
      TRAP      = 3'd5
   } stateT;

   typedef enum logic [2:0] {
      CL_NONE = 3'd0,
      CL_R    = 3'd1,
      CL_LD   = 3'd2,
      CL_SD   = 3'd3,
      CL_BEQ  = 3'd4,
      CL_IALU = 3'd5,
      CL_JAL  = 3'd6
   } classT;

   // The wait counter only has to reach TIMEOUT, so it is sized for that value
   // and saturates there instead of wrapping.
   localparam int              CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   CAP  = CW'(TIMEOUT);
   localparam logic [CW-1:0]   LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   stateT         state_q, state_d;
   classT         class_q, class_d;
   classT         decodedClass;
   logic [CW-1:0] waitCnt_q, waitCnt_d;
   logic          memWait;
   logic          timeoutHit;

   // A memory wait is any FETCH or MEMORY cycle without a ready handshake.
   // The watchdog fires on the wait cycle that brings the count to TIMEOUT.
   assign memWait    = ((state_q == FETCH) || (state_q == MEMORY)) && !memoryReady;
   assign timeoutHit = (TIMEOUT != 0) && memWait && (waitCnt_q == LAST);

   // Opcode to instruction class. Disabled classes fall through to CL_NONE, which traps.
   always_comb begin
      decodedClass = CL_NONE;
      case (opcode)
         7'b0110011: decodedClass = CL_R;
         7'b0000011: decodedClass = CL_LD;
         7'b0100011: decodedClass = CL_SD;
         7'b1100011: decodedClass = CL_BEQ;
         7'b0010011: if (ENABLE_IMM_ALU) decodedClass = CL_IALU;
         7'b1101111: if (ENABLE_JAL) decodedClass = CL_JAL;
         default:    decodedClass = CL_NONE;
      endcase
   end

   // Next-state logic. The class register is updated only in DECODE, so later
   // changes on opcode are ignored until the next DECODE.
   always_comb begin
      state_d = state_q;
      class_d = class_q;
      case (state_q)
         FETCH: begin
            if (memoryReady)     state_d = DECODE;
            else if (timeoutHit) state_d = TRAP;
         end
         DECODE: begin
            class_d = decodedClass;
            state_d = (decodedClass == CL_NONE) ? TRAP : EXECUTE;
         end
         EXECUTE: begin
            case (class_q)
               CL_R, CL_IALU, CL_JAL: state_d = WRITEBACK;
               CL_LD, CL_SD:         state_d = MEMORY;
               CL_BEQ:               state_d = FETCH;
               default:              state_d = TRAP;
            endcase
         end
         MEMORY: begin
            if ((class_q != CL_LD) && (class_q != CL_SD)) state_d = TRAP;
            else if (memoryReady) state_d = (class_q == CL_LD) ? WRITEBACK : FETCH;
            else if (timeoutHit)  state_d = TRAP;
         end
         WRITEBACK: state_d = FETCH;
         TRAP:      state_d = TRAP;
         default:   state_d = TRAP;
      endcase
   end

   // The wait counter runs only across consecutive stalled cycles in the same
   // state. Completing the access or changing state clears it.
   always_comb begin
      waitCnt_d = '0;
      if (memWait && (state_d == state_q)) begin
         waitCnt_d = (waitCnt_q == CAP) ? waitCnt_q : waitCnt_q + 1'b1;
      end
   end

   // State, class and wait-counter registers, with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= FETCH;
         class_q   <= CL_NONE;
         waitCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         waitCnt_q <= waitCnt_d;
      end
   end

   // Moore output decode from state and class. While reset is asserted,
   // every control output is held at 0 so that no partial access leaks out.
   always_comb begin
      ALUOp            = 2'b00;
      ALUSrc           = 1'b0;
      memoryToRegister = 1'b0;
      rWrite           = 1'b0;
      memoryRead       = 1'b0;
      memoryWrite      = 1'b0;
      branch           = 1'b0;
      jump             = 1'b0;
      PCWrite          = 1'b0;
      IRWrite          = 1'b0;
      illegal          = 1'b0;
      if (!reset) begin
         case (state_q)
            FETCH: begin
               memoryRead = 1'b1;
               if (memoryReady) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
               end
            end
            EXECUTE: begin
               case (class_q)
                  CL_R:    ALUOp = 2'b10;
                  CL_IALU: begin ALUSrc = 1'b1; ALUOp = 2'b11; end
                  CL_LD,
                  CL_SD:   ALUSrc = 1'b1;
                  CL_BEQ:  begin ALUOp = 2'b01; branch = 1'b1; end
                  CL_JAL:  jump = 1'b1;
                  default: ALUOp = 2'b00;
               endcase
            end
            MEMORY: begin
               memoryRead  = (class_q == CL_LD);
               memoryWrite = (class_q == CL_SD);
            end
            WRITEBACK: begin
               rWrite           = 1'b1;
               memoryToRegister = (class_q == CL_LD);
               jump             = (class_q == CL_JAL);
            end
            TRAP:    illegal = 1'b1;
            default: illegal = 1'b0;
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller. Three instances share their
// inputs: the default configuration, a 4-cycle-timeout build with I-ALU and JAL
// disabled, and a build with the timeout disabled.
module tb_multicycle_controller;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_SD   = 7'b0100011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_IALU = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BAD  = 7'b1111111;

   localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;

   // Control vector layout:
   // {ALUOp[1:0], ALUSrc, memoryToRegister, rWrite, memoryRead, memoryWrite,
   //  branch, jump, PCWrite, IRWrite, illegal}
   localparam logic [11:0] C_ZERO   = 12'b00_0_0_0_0_0_0_0_0_0_0;
   localparam logic [11:0] C_FRDY   = 12'b00_0_0_0_1_0_0_0_1_1_0;
   localparam logic [11:0] C_FWAIT  = 12'b00_0_0_0_1_0_0_0_0_0_0;
   localparam logic [11:0] C_EXR    = 12'b10_0_0_0_0_0_0_0_0_0_0;
   localparam logic [11:0] C_EXI    = 12'b11_1_0_0_0_0_0_0_0_0_0;
   localparam logic [11:0] C_EXMEM  = 12'b00_1_0_0_0_0_0_0_0_0_0;
   localparam logic [11:0] C_EXBEQ  = 12'b01_0_0_0_0_0_1_0_0_0_0;
   localparam logic [11:0] C_EXJAL  = 12'b00_0_0_0_0_0_0_1_0_0_0;
   localparam logic [11:0] C_MLD    = 12'b00_0_0_0_1_0_0_0_0_0_0;
   localparam logic [11:0] C_MSD    = 12'b00_0_0_0_0_1_0_0_0_0_0;
   localparam logic [11:0] C_WBR    = 12'b00_0_0_1_0_0_0_0_0_0_0;
   localparam logic [11:0] C_WBLD   = 12'b00_0_1_1_0_0_0_0_0_0_0;
   localparam logic [11:0] C_WBJAL  = 12'b00_0_0_1_0_0_0_1_0_0_0;
   localparam logic [11:0] C_TRAP   = 12'b00_0_0_0_0_0_0_0_0_0_1;

   logic       clock;
   logic       reset;
   logic [6:0] opcode;
   logic       memoryReady;

   logic [1:0] aluOpA, aluOpB, aluOpC;
   logic       aluSrcA, aluSrcB, aluSrcC;
   logic       m2rA, m2rB, m2rC;
   logic       rWriteA, rWriteB, rWriteC;
   logic       mReadA, mReadB, mReadC;
   logic       mWriteA, mWriteB, mWriteC;
   logic       branchA, branchB, branchC;
   logic       jumpA, jumpB, jumpC;
   logic       pcWriteA, pcWriteB, pcWriteC;
   logic       irWriteA, irWriteB, irWriteC;
   logic       illegalA, illegalB, illegalC;
   logic [2:0] stateA, stateB, stateC;
   logic [11:0] ctrlA, ctrlB, ctrlC;

   int testsRun;
   int failCount;

   assign ctrlA = {aluOpA, aluSrcA, m2rA, rWriteA, mReadA, mWriteA, branchA, jumpA, pcWriteA, irWriteA, illegalA};
   assign ctrlB = {aluOpB, aluSrcB, m2rB, rWriteB, mReadB, mWriteB, branchB, jumpB, pcWriteB, irWriteB, illegalB};
   assign ctrlC = {aluOpC, aluSrcC, m2rC, rWriteC, mReadC, mWriteC, branchC, jumpC, pcWriteC, irWriteC, illegalC};

   multicycle_controller dutA (
      .clock(clock), .reset(reset), .opcode(opcode), .memoryReady(memoryReady),
      .ALUOp(aluOpA), .ALUSrc(aluSrcA), .memoryToRegister(m2rA), .rWrite(rWriteA),
      .memoryRead(mReadA), .memoryWrite(mWriteA), .branch(branchA), .jump(jumpA),
      .PCWrite(pcWriteA), .IRWrite(irWriteA), .illegal(illegalA), .state(stateA)
   );

   multicycle_controller #(.TIMEOUT(4), .ENABLE_IMM_ALU(1'b0), .ENABLE_JAL(1'b0)) dutB (
      .clock(clock), .reset(reset), .opcode(opcode), .memoryReady(memoryReady),
      .ALUOp(aluOpB), .ALUSrc(aluSrcB), .memoryToRegister(m2rB), .rWrite(rWriteB),
      .memoryRead(mReadB), .memoryWrite(mWriteB), .branch(branchB), .jump(jumpB),
      .PCWrite(pcWriteB), .IRWrite(irWriteB), .illegal(illegalB), .state(stateB)
   );

   multicycle_controller #(.TIMEOUT(0)) dutC (
      .clock(clock), .reset(reset), .opcode(opcode), .memoryReady(memoryReady),
      .ALUOp(aluOpC), .ALUSrc(aluSrcC), .memoryToRegister(m2rC), .rWrite(rWriteC),
      .memoryRead(mReadC), .memoryWrite(mWriteC), .branch(branchC), .jump(jumpC),
      .PCWrite(pcWriteC), .IRWrite(irWriteC), .illegal(illegalC), .state(stateC)
   );

   // Free-running clock with rising edges at 5, 15, 25, ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives the inputs shortly after a rising edge, then lets the combinational outputs settle.
   task automatic applyStimulus(input logic r, input logic [6:0] op, input logic mr);
      reset       = r;
      opcode      = op;
      memoryReady = mr;
      #2;
   endtask

   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   // One cycle of the default instance: drive, check state and controls, advance.
   task automatic cyc(input logic [6:0] op, input logic mr, input string tag,
                      input logic [2:0] expState, input logic [11:0] expCtrl);
      applyStimulus(1'b0, op, mr);
      checkOutput({tag, ".state"}, 32'(stateA), 32'(expState));
      checkOutput({tag, ".ctrl"}, 32'(ctrlA), 32'(expCtrl));
      nextCycle();
   endtask

   // Synchronous reset of all instances. Controls must read 0 while reset is high.
   task automatic resetAll(input string tag);
      applyStimulus(1'b1, OP_R, 1'b1);
      checkOutput({tag, ".rstCtrlA"}, 32'(ctrlA), 32'(C_ZERO));
      checkOutput({tag, ".rstCtrlB"}, 32'(ctrlB), 32'(C_ZERO));
      nextCycle();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      testsRun    = 0;
      failCount   = 0;
      reset       = 1'b1;
      opcode      = OP_R;
      memoryReady = 1'b1;
      nextCycle();
      resetAll("init");
      checkOutput("init.stateA", 32'(stateA), 32'(S_F));

      // R-type: F, D, E, W, F
      cyc(OP_R, 1'b1, "r.f",  S_F, C_FRDY);
      cyc(OP_R, 1'b1, "r.d",  S_D, C_ZERO);
      cyc(OP_R, 1'b1, "r.e",  S_E, C_EXR);
      cyc(OP_R, 1'b1, "r.w",  S_W, C_WBR);
      cyc(OP_R, 1'b1, "r.f2", S_F, C_FRDY);

      // Load with three stalled MEMORY cycles: eight cycles in total
      resetAll("ld");
      cyc(OP_LD, 1'b1, "ld.f",  S_F, C_FRDY);
      cyc(OP_LD, 1'b1, "ld.d",  S_D, C_ZERO);
      cyc(OP_LD, 1'b1, "ld.e",  S_E, C_EXMEM);
      cyc(OP_LD, 1'b0, "ld.m0", S_M, C_MLD);
      cyc(OP_LD, 1'b0, "ld.m1", S_M, C_MLD);
      cyc(OP_LD, 1'b0, "ld.m2", S_M, C_MLD);
      cyc(OP_LD, 1'b1, "ld.m3", S_M, C_MLD);
      cyc(OP_LD, 1'b1, "ld.w",  S_W, C_WBLD);
      cyc(OP_LD, 1'b1, "ld.f2", S_F, C_FRDY);

      // Branch: back in FETCH after three cycles, with no register write
      resetAll("beq");
      cyc(OP_BEQ, 1'b1, "beq.f",  S_F, C_FRDY);
      cyc(OP_BEQ, 1'b1, "beq.d",  S_D, C_ZERO);
      cyc(OP_BEQ, 1'b1, "beq.e",  S_E, C_EXBEQ);
      cyc(OP_BEQ, 1'b1, "beq.f2", S_F, C_FRDY);

      // JAL on the default build; dutB has JAL disabled and traps after DECODE
      resetAll("jal");
      cyc(OP_JAL, 1'b1, "jal.f", S_F, C_FRDY);
      cyc(OP_JAL, 1'b1, "jal.d", S_D, C_ZERO);
      checkOutput("jal.dutBstate", 32'(stateB), 32'(S_T));
      checkOutput("jal.dutBctrl", 32'(ctrlB), 32'(C_TRAP));
      cyc(OP_JAL, 1'b1, "jal.e", S_E, C_EXJAL);
      cyc(OP_JAL, 1'b1, "jal.w", S_W, C_WBJAL);
      cyc(OP_JAL, 1'b1, "jal.f2", S_F, C_FRDY);

      // I-type ALU on the default build; dutB has it disabled and traps
      resetAll("ialu");
      cyc(OP_IALU, 1'b1, "ialu.f", S_F, C_FRDY);
      cyc(OP_IALU, 1'b1, "ialu.d", S_D, C_ZERO);
      checkOutput("ialu.dutBstate", 32'(stateB), 32'(S_T));
      cyc(OP_IALU, 1'b1, "ialu.e", S_E, C_EXI);
      cyc(OP_IALU, 1'b1, "ialu.w", S_W, C_WBR);
      cyc(OP_IALU, 1'b1, "ialu.f2", S_F, C_FRDY);

      // Illegal opcode: TRAP is sticky and survives opcode and ready changes
      resetAll("bad");
      cyc(OP_BAD, 1'b1, "bad.f", S_F, C_FRDY);
      cyc(OP_BAD, 1'b1, "bad.d", S_D, C_ZERO);
      for (int i = 0; i < 12; i++) begin
         cyc((i % 2 == 0) ? OP_R : OP_LD, 1'(i % 2), $sformatf("bad.trap%0d", i), S_T, C_TRAP);
      end
      resetAll("badclr");
      cyc(OP_R, 1'b1, "badclr.f", S_F, C_FRDY);

      // Fetch stall: dutB (TIMEOUT=4) traps on cycle 5, dutA (TIMEOUT=16) traps on
      // cycle 17, and dutC (timeout disabled) waits forever
      resetAll("tmo");
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(1'b0, OP_R, 1'b0);
         checkOutput($sformatf("tmo.B%0d", i), 32'(stateB), 32'((i >= 5) ? S_T : S_F));
         checkOutput($sformatf("tmo.A%0d", i), 32'(stateA), 32'((i >= 17) ? S_T : S_F));
         checkOutput($sformatf("tmo.Actrl%0d", i), 32'(ctrlA), 32'((i >= 17) ? C_TRAP : C_FWAIT));
         checkOutput($sformatf("tmo.C%0d", i), 32'(stateC), 32'(S_F));
         checkOutput($sformatf("tmo.Cctrl%0d", i), 32'(ctrlC), 32'(C_FWAIT));
         nextCycle();
      end

      // Store whose opcode switches to R after DECODE: still a store, with no rWrite
      resetAll("sd");
      cyc(OP_SD, 1'b1, "sd.f",  S_F, C_FRDY);
      cyc(OP_SD, 1'b1, "sd.d",  S_D, C_ZERO);
      cyc(OP_R,  1'b1, "sd.e",  S_E, C_EXMEM);
      cyc(OP_R,  1'b0, "sd.m0", S_M, C_MSD);
      cyc(OP_R,  1'b1, "sd.m1", S_M, C_MSD);
      cyc(OP_R,  1'b1, "sd.f2", S_F, C_FRDY);
      cyc(OP_R,  1'b1, "sd.d2", S_D, C_ZERO);

      // Reset asserted mid-MEMORY drops memoryWrite in the same cycle, then goes to FETCH
      resetAll("sdrst");
      cyc(OP_SD, 1'b1, "sdrst.f", S_F, C_FRDY);
      cyc(OP_SD, 1'b1, "sdrst.d", S_D, C_ZERO);
      cyc(OP_SD, 1'b1, "sdrst.e", S_E, C_EXMEM);
      cyc(OP_SD, 1'b0, "sdrst.m", S_M, C_MSD);
      applyStimulus(1'b1, OP_SD, 1'b0);
      checkOutput("sdrst.rstState", 32'(stateA), 32'(S_M));
      checkOutput("sdrst.rstCtrl", 32'(ctrlA), 32'(C_ZERO));
      nextCycle();
      cyc(OP_SD, 1'b1, "sdrst.f2", S_F, C_FRDY);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
